move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
// Sequences snake motion: buffers direction commands from the input handler and releases one per move tick.
// Generates the one-cycle mover pulse and the accion code consumed by GameLogic, and handles pause and game-over.
// Shortens the tick period each time food is eaten, so the game speeds up.
// Replaces the free-running movement counter and the direction FSM in the top level.
// PARAMETERS
// TICK_INIT   4000000  initial move period, clk cycles
// TICK_MIN    1000000  floor for the move period
// TICK_STEP   200000   period decrement per comer pulse
// QDEPTH_LOG2 2        command queue depth = 2**QDEPTH_LOG2 (4)
// PORTS
// clk        in   1   system clock
// rst        in   1   asynchronous reset, active-low
// cmd_valid  in   1   one-cycle strobe: new command on cmd_code
// cmd_code   in   3   0 none, 1 up, 2 down, 3 left, 4 right, 5 pause; 6/7 illegal
// comer      in   1   one-cycle pulse: food eaten
// game_over  in   1   level: collision detected by GameLogic
// mover      out  1   one-cycle move strobe
// accion     out  3   current direction (0 none, 1..4), valid while mover is high
// paused     out  1   high in PAUSE state
// q_count    out  3   queued command count, 0..4
// q_drop     out  1   one-cycle pulse: command rejected because the queue is full
// period     out  32  active tick period
// BEHAVIOUR
// Reset (rst low, async) forces all outputs and state as follows:
// - state IDLE; accion, mover, paused, q_count and q_drop = 0; period = TICK_INIT; tick counter = 0; queue empty.
// FSM transitions:
// - IDLE -> RUN on the first dequeued cmd 1..4; accion takes that value.
// - RUN -> PAUSE on cmd 5; PAUSE -> RUN on cmd 5.
// - Any state -> OVER while game_over = 1; OVER is left only by reset.
// Pause handling:
// - cmd 5 bypasses the queue and takes effect the cycle after cmd_valid.
// - cmd 5 in IDLE and OVER is ignored.
// Command filtering:
// - cmd 0, 6 and 7 are ignored and never enqueued.
// - cmd 1..4 is enqueued in RUN and IDLE. In PAUSE it is dropped silently, with no q_drop.
// Tick counter:
// - Counts only in RUN and IDLE; frozen in PAUSE and OVER.
// - When the counter reaches period-1 it clears to 0, and on that same cycle mover = 1 for exactly one cycle.
// - Every mover cycle dequeues one entry if q_count > 0.
// Applying a dequeued command:
// - Applied before mover is issued, so the new accion is visible on the same cycle mover = 1.
// - Ignored when it is a reversal (1<->2, 3<->4) or equal to the current accion.
// - An ignored entry is still consumed; it does not carry over to the next tick.
// - In IDLE with no valid command, accion stays 0 and mover still pulses.
// Queue:
// - FIFO; q_count is updated on the cycle after each push or pop.
// - Push and pop in the same cycle: q_count unchanged and data order preserved, including when the queue is full.
// - Push when full with no pop: entry discarded and q_drop = 1 for one cycle.
// Speed-up on comer:
// - period <= max(period - TICK_STEP, TICK_MIN), with saturating 32-bit arithmetic and no wrap below TICK_MIN.
// - Takes effect from the next counter compare.
// - If the counter is already >= the new period-1, the tick fires on the next cycle.
// - comer in PAUSE, IDLE or OVER is ignored.
// Simultaneous events:
// - game_over on a tick cycle: no mover is issued, and the state becomes OVER.
// - cmd 5 on a tick cycle: the tick still completes, then the state becomes PAUSE.
// Reset mid-tick or mid-pause returns to the full reset values above.
// TESTING
// 1. TICK_INIT=10. Reset, push cmd 4 -> mover at cycle 10 with accion=4, then every 10 cycles; q_count back to 0.
// 2. In RUN with accion 4, push 3, 1 -> the next tick keeps accion=4 (3 consumed), the tick after that gives accion=1.
// 3. Push 5 cmds within one period -> q_count=4, q_drop pulses once; four subsequent ticks drain the queue in order.
// 4. period=10, TICK_STEP=4, TICK_MIN=3. Three comer pulses -> period reads 6, 3, 3.
// 5. cmd 5 mid-period -> mover absent for 100 cycles and the counter is held; a second cmd 5 resumes, and the tick lands at the remaining count.
// 6. game_over asserted on a tick cycle -> no mover, state OVER, comer/cmd ignored. rst low -> all outputs 0, period = TICK_INIT, immediately and with no clock edge.

Source files
------------

// File: rtl/move_scheduler.sv
// Move scheduler for the snake game: queues direction commands, releases one per move tick,
// drives the mover strobe and accion code, handles pause/game-over and speeds up on food.
module move_scheduler #(
    parameter int unsigned TICK_INIT   = 4000000,
    parameter int unsigned TICK_MIN    = 1000000,
    parameter int unsigned TICK_STEP   = 200000,
    parameter int unsigned QDEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    input  logic        comer,
    input  logic        game_over,
    output logic        mover,
    output logic [2:0]  accion,
    output logic        paused,
    output logic [2:0]  q_count,
    output logic        q_drop,
    output logic [31:0] period
);
    localparam int QDEPTH = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0]   CNT_ONE  = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2:0]   CNT_FULL = {1'b1, {QDEPTH_LOG2{1'b0}}};
    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    state_t                 state_reg;
    logic [31:0]            cnt_reg;
    logic [31:0]            period_reg;
    logic [2:0]             accion_reg;
    logic                   mover_reg;
    logic                   q_drop_reg;
    logic [QDEPTH_LOG2-1:0] rd_ptr_reg;
    logic [QDEPTH_LOG2-1:0] wr_ptr_reg;
    logic [QDEPTH_LOG2:0]   count_reg;
    logic [2:0]             mem_reg [QDEPTH];

    logic        counting;
    logic        tick;
    logic        is_move_cmd;
    logic        pause_cmd;
    logic        push_req;
    logic        full;
    logic        pop;
    logic        push;
    logic        head_ok;
    logic [2:0]  head;
    logic [2:0]  opposite;
    logic [31:0] period_dec;

    assign counting    = (state_reg == IDLE) || (state_reg == RUN);
    // Compare with >= so a period shortened below the running count fires on the next cycle.
    assign tick        = counting && !game_over && (cnt_reg >= period_reg - 32'd1);
    assign is_move_cmd = cmd_valid && (cmd_code >= 3'd1) && (cmd_code <= 3'd4);
    assign pause_cmd   = cmd_valid && (cmd_code == 3'd5);
    assign push_req    = is_move_cmd && counting && !game_over;
    assign full        = (count_reg == CNT_FULL);
    assign pop         = tick && (count_reg != '0);
    assign push        = push_req && (!full || pop);
    assign head        = mem_reg[rd_ptr_reg];

    always_comb begin
        opposite = 3'd0;
        case (head)
            3'd1:    opposite = 3'd2;
            3'd2:    opposite = 3'd1;
            3'd3:    opposite = 3'd4;
            3'd4:    opposite = 3'd3;
            default: opposite = 3'd0;
        endcase
    end

    // A popped entry is consumed even when it is a reversal or a repeat of the current heading.
    assign head_ok = pop && (head != accion_reg) && (opposite != accion_reg);

    assign period_dec = ({1'b0, period_reg} >= ({1'b0, TICK_MIN} + {1'b0, TICK_STEP}))
                        ? (period_reg - TICK_STEP) : TICK_MIN;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= cmd_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            period_reg <= TICK_INIT;
            accion_reg <= 3'd0;
            mover_reg  <= 1'b0;
            q_drop_reg <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            mover_reg  <= tick;
            q_drop_reg <= push_req && full && !pop;

            if (game_over) begin
                state_reg <= OVER;
            end else begin
                case (state_reg)
                    IDLE:    if (head_ok)   state_reg <= RUN;
                    RUN:     if (pause_cmd) state_reg <= PAUSE;
                    PAUSE:   if (pause_cmd) state_reg <= RUN;
                    default: state_reg <= OVER;
                endcase
            end

            if (head_ok) begin
                accion_reg <= head;
            end
            if (counting && !game_over) begin
                cnt_reg <= tick ? 32'd0 : cnt_reg + 32'd1;
            end
            if (comer && (state_reg == RUN) && !game_over) begin
                period_reg <= period_dec;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    assign mover   = mover_reg;
    assign accion  = accion_reg;
    assign paused  = (state_reg == PAUSE);
    assign q_count = 3'(count_reg);
    assign q_drop  = q_drop_reg;
    assign period  = period_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: a queue-based reference model predicts each cycle's
// outputs, a monitor compares them one cycle later.
module tb_move_scheduler;
    localparam int unsigned TI = 10;
    localparam int unsigned TM = 3;
    localparam int unsigned TS = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_code = 3'd0;
    logic        comer = 1'b0;
    logic        game_over = 1'b0;
    logic        mover;
    logic [2:0]  accion;
    logic        paused;
    logic [2:0]  q_count;
    logic        q_drop;
    logic [31:0] period;

    always #5 clk = ~clk;

    move_scheduler #(
        .TICK_INIT(TI), .TICK_MIN(TM), .TICK_STEP(TS), .QDEPTH_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .comer(comer), .game_over(game_over), .mover(mover), .accion(accion),
        .paused(paused), .q_count(q_count), .q_drop(q_drop), .period(period)
    );

    typedef struct {
        bit mover;
        int accion;
        bit paused;
        int qc;
        bit drop;
        int per;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: game state, tick count, period, heading and the pending command list.
    int m_state;
    int m_cnt;
    int m_per;
    int m_acc;
    int m_fifo[$];

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endfunction

    function automatic int rev(int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_per   = TI;
        m_acc   = 0;
        m_fifo.delete();
    endfunction

    function automatic void push_exp(bit mv, bit drop);
        exp_t e;
        e.mover  = mv;
        e.accion = m_acc;
        e.paused = (m_state == M_PAUSE);
        e.qc     = m_fifo.size();
        e.drop   = drop;
        e.per    = m_per;
        exp_q.push_back(e);
    endfunction

    // One clock of the game rules, given the inputs presented for that edge.
    function automatic void step(bit cv, int cc, bit cm, bit go);
        int old_state = m_state;
        bit mv = 1'b0;
        bit drop = 1'b0;
        int c;
        if (go) begin
            m_state = M_OVER;
        end else if (old_state == M_IDLE || old_state == M_RUN) begin
            if (m_cnt + 1 >= m_per) begin
                mv = 1'b1;
                m_cnt = 0;
                if (m_fifo.size() > 0) begin
                    c = m_fifo.pop_front();
                    if (c != m_acc && c != rev(m_acc)) begin
                        m_acc = c;
                        if (old_state == M_IDLE) m_state = M_RUN;
                    end
                end
            end else begin
                m_cnt++;
            end
            if (cv && cc >= 1 && cc <= 4) begin
                if (m_fifo.size() < 4) m_fifo.push_back(cc);
                else drop = 1'b1;
            end
            if (cm && old_state == M_RUN)
                m_per = (m_per - int'(TS) < int'(TM)) ? int'(TM) : m_per - int'(TS);
            if (cv && cc == 5 && old_state == M_RUN) m_state = M_PAUSE;
        end else if (old_state == M_PAUSE && cv && cc == 5) begin
            m_state = M_RUN;
        end
        push_exp(mv, drop);
    endfunction

    task automatic drive(bit cv, int cc, bit cm, bit go);
        @(negedge clk);
        cmd_valid = cv;
        cmd_code  = 3'(cc);
        comer     = cm;
        game_over = go;
        step(cv, cc, cm, go);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_code = 3'd0;
        comer = 1'b0;
        game_over = 1'b0;
        #1;
        check("rst_mover", int'(mover), 0);
        check("rst_accion", int'(accion), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_q_count", int'(q_count), 0);
        check("rst_q_drop", int'(q_drop), 0);
        check("rst_period", int'(period), int'(TI));
        model_reset();
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mover", int'(mover), int'(e.mover));
                check("paused", int'(paused), int'(e.paused));
                check("q_count", int'(q_count), e.qc);
                check("q_drop", int'(q_drop), int'(e.drop));
                check("period", int'(period), e.per);
                if (e.mover) begin
                    check("accion", int'(accion), e.accion);
                    $display("move t=%0t accion=%0d period=%0d q_count=%0d", $time, accion, period, q_count);
                end
            end
        end
    end

    initial begin : stimulus
        int cc;
        int guard;
        do_reset();

        // First command from IDLE, then a reversal followed by a valid turn.
        drive(1'b1, 4, 1'b0, 1'b0);
        idle(24);
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        idle(22);

        // Overfill the queue: the fifth push is dropped, four ticks drain in order.
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0);
        drive(1'b1, 4, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        idle(45);

        // Pause mid-period for 100 cycles, with ignored commands and food while paused.
        idle(4);
        drive(1'b1, 5, 1'b0, 1'b0);
        idle(30);
        drive(1'b1, 2, 1'b1, 1'b0);
        idle(69);
        drive(1'b1, 5, 1'b0, 1'b0);
        idle(20);

        // Speed-up down to the floor.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b1, 1'b0);
            idle(7);
        end

        // Randomized traffic with a reset dropped in midway.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cc = int'($urandom_range(0, 7));
            if (cc == 5 && $urandom_range(0, 3) != 0) cc = int'($urandom_range(1, 4));
            drive(($urandom_range(0, 2) == 0), cc, ($urandom_range(0, 99) == 0), 1'b0);
        end

        // game_over on a tick cycle, then everything is ignored until reset.
        do_reset();
        drive(1'b1, 2, 1'b0, 1'b0);
        guard = 0;
        while (!(m_state == M_RUN && m_cnt + 1 >= m_per) && guard < 100) begin
            drive(1'b0, 0, 1'b0, 1'b0);
            guard++;
        end
        check("reach_tick_in_run", int'(guard < 100), 1);
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, (i % 6), (i % 3 == 0), (i < 10));
        do_reset();
        idle(3);

        @(negedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
